// File: rtl/crc_decoding_if.sv
`default_nettype none
// ============================================================================
// Module   : crc_decoding_if
// Desc     : Serial-in / decoded-packet-out bundle for the CRC decoder.
//            master = bit source + packet consumer, slave = decoder.
// Revision : 1.0  initial release
// ============================================================================
interface crc_decoding_if #(
    parameter int MAX_BYTES = 8
);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic                   bIn;
    logic                   bInAvail;
    logic                   pktEnd;
    logic                   pktAck;
    logic                   pktOutAvail;
    logic [3:0]             pid;
    logic [6:0]             addr;
    logic [3:0]             endp;
    logic [MAX_BYTES*8-1:0] data;
    logic [LEN_W-1:0]       dataLen;
    logic                   crcOk;
    logic                   pidErr;
    logic                   lenErr;
    logic                   dropped;

    modport master (
        output bIn, bInAvail, pktEnd, pktAck,
        input  pktOutAvail, pid, addr, endp, data, dataLen,
               crcOk, pidErr, lenErr, dropped
    );

    modport slave (
        input  bIn, bInAvail, pktEnd, pktAck,
        output pktOutAvail, pid, addr, endp, data, dataLen,
               crcOk, pidErr, lenErr, dropped
    );
endinterface
`default_nettype wire

// File: rtl/crc_decoding.sv
`default_nettype none
// ============================================================================
// Module   : crc_decoding
// Desc     : Serial packet decoder: PID, token/data fields, CRC5/CRC16 check,
//            valid/ack result hand-off. Macro CRC16_CHECK_EN adds CRC16.
// Revision : 1.0  initial release
// ============================================================================
module crc_decoding #(
    parameter int MAX_BYTES = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    crc_decoding_if.slave bus
);
    localparam int DATA_W   = MAX_BYTES * 8;
    localparam int BUF_BITS = DATA_W + 16;
    localparam int IDX_W    = $clog2(BUF_BITS);
    localparam int CNT_W    = IDX_W + 1;
    localparam int LEN_W    = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] c_buf_bits  = CNT_W'(BUF_BITS);
    localparam logic [CNT_W-1:0] c_crc_bits  = CNT_W'(16);
    localparam logic [CNT_W-1:0] c_max_bytes = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_pid_last  = CNT_W'(7);

    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_BODY, ST_HOLD} state_t;

    state_t                r_state, w_state_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic [7:0]            r_pid_raw, w_pid_nx;
    logic [BUF_BITS-1:0]   r_buf, w_buf_nx;
    logic [4:0]            r_crc5, w_crc5_nx, w_crc5_sh;
    logic                  w_load, w_abort, w_clear, w_drop;
    logic                  w_dat_good;

    assign w_crc5_sh = {r_crc5[3:0], 1'b0} ^ ((r_crc5[4] ^ bus.bIn) ? 5'h05 : 5'h00);

`ifdef CRC16_CHECK_EN
    logic [15:0] r_crc16, w_crc16_nx, w_crc16_sh;
    assign w_crc16_sh = {r_crc16[14:0], 1'b0} ^ ((r_crc16[15] ^ bus.bIn) ? 16'h8005 : 16'h0000);
    assign w_dat_good = (w_crc16_nx == 16'h800D);
`else
    assign w_dat_good = 1'b1;
`endif

    // Next-state and next-datapath values; the end evaluation below reads the
    // *_nx values so a bit arriving together with pktEnd is already included.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pid_nx   = r_pid_raw;
        w_buf_nx   = r_buf;
        w_crc5_nx  = r_crc5;
`ifdef CRC16_CHECK_EN
        w_crc16_nx = r_crc16;
`endif
        w_load     = 1'b0;
        w_abort    = 1'b0;
        w_clear    = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.bInAvail) begin
                    w_pid_nx   = {7'b0, bus.bIn};
                    w_cnt_nx   = CNT_W'(1);
                    w_buf_nx   = '0;
                    w_state_nx = ST_PID;
                end
            end
            ST_PID: begin
                if (bus.bInAvail) begin
                    w_pid_nx[r_cnt[2:0]] = bus.bIn;
                    if (r_cnt == c_pid_last) begin
                        w_cnt_nx   = '0;
                        w_crc5_nx  = 5'h1F;
`ifdef CRC16_CHECK_EN
                        w_crc16_nx = 16'hFFFF;
`endif
                        w_state_nx = ST_BODY;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                if (bus.pktEnd) begin
                    w_load     = 1'b1;
                    w_abort    = !(bus.bInAvail && (r_cnt == c_pid_last));
                    w_state_nx = ST_HOLD;
                end
            end
            ST_BODY: begin
                if (bus.bInAvail) begin
                    if (r_cnt < c_buf_bits) begin
                        w_buf_nx[r_cnt[IDX_W-1:0]] = bus.bIn;
                    end
                    if (r_cnt != c_cnt_max) begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                    w_crc5_nx  = w_crc5_sh;
`ifdef CRC16_CHECK_EN
                    w_crc16_nx = w_crc16_sh;
`endif
                end
                if (bus.pktEnd) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_HOLD;
                end
            end
            default: begin
                w_drop = bus.bInAvail | bus.pktEnd;
                if (bus.pktAck) begin
                    w_clear    = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // End-of-packet evaluation
    logic                  w_is_tok, w_is_dat, w_is_hs, w_dat_len_ok, w_good;
    logic [CNT_W-1:0]      w_body, w_nbytes, w_len_cl;
    logic                  w_e_pid_err, w_e_len_err, w_e_crc_ok;
    logic [6:0]            w_e_addr;
    logic [3:0]            w_e_endp;
    logic [DATA_W-1:0]     w_e_data;
    logic [LEN_W-1:0]      w_e_len;

    always_comb begin
        w_is_tok = 1'b0;
        w_is_dat = 1'b0;
        w_is_hs  = 1'b0;
        case (w_pid_nx[3:0])
            4'b0001, 4'b1001, 4'b0101, 4'b1101: w_is_tok = 1'b1;
            4'b0011, 4'b1011:                   w_is_dat = 1'b1;
            4'b0010, 4'b1010, 4'b1110:          w_is_hs  = 1'b1;
            default: ;
        endcase
        w_body       = w_cnt_nx - c_crc_bits;
        w_nbytes     = w_body >> 3;
        w_dat_len_ok = (w_cnt_nx >= c_crc_bits) && (w_body[2:0] == 3'b000) &&
                       (w_nbytes <= c_max_bytes);
        w_e_pid_err  = (w_pid_nx[7:4] != ~w_pid_nx[3:0]) || !(w_is_tok || w_is_dat || w_is_hs);
        w_e_len_err  = (w_cnt_nx == c_cnt_max) ||
                       (w_is_tok && (w_cnt_nx != c_crc_bits)) ||
                       (w_is_dat && !w_dat_len_ok) ||
                       (w_is_hs  && (w_cnt_nx != '0));
        if (!w_is_dat || (w_cnt_nx < c_crc_bits)) begin
            w_len_cl = '0;
        end else if (w_nbytes > c_max_bytes) begin
            w_len_cl = c_max_bytes;
        end else begin
            w_len_cl = w_nbytes;
        end
        w_e_len  = w_len_cl[LEN_W-1:0];
        w_e_data = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (b < int'(w_len_cl)) begin
                w_e_data[b*8 +: 8] = w_buf_nx[b*8 +: 8];
            end
        end
        w_e_addr   = w_is_tok ? w_buf_nx[6:0]  : 7'd0;
        w_e_endp   = w_is_tok ? w_buf_nx[10:7] : 4'd0;
        w_good     = w_is_tok ? (w_crc5_nx == 5'h0C) : (w_is_dat ? w_dat_good : 1'b1);
        w_e_crc_ok = !w_e_pid_err && !w_e_len_err && w_good;
        // Packet ended before a full PID byte: nothing else is trustworthy
        if (w_abort) begin
            w_e_pid_err = 1'b1;
            w_e_len_err = 1'b1;
            w_e_crc_ok  = 1'b0;
            w_e_addr    = '0;
            w_e_endp    = '0;
            w_e_data    = '0;
            w_e_len     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_cnt     <= '0;
            r_pid_raw <= '0;
            r_buf     <= '0;
            r_crc5    <= 5'h1F;
`ifdef CRC16_CHECK_EN
            r_crc16   <= 16'hFFFF;
`endif
        end else begin
            r_cnt     <= w_cnt_nx;
            r_pid_raw <= w_pid_nx;
            r_buf     <= w_buf_nx;
            r_crc5    <= w_crc5_nx;
`ifdef CRC16_CHECK_EN
            r_crc16   <= w_crc16_nx;
`endif
        end
    end

    logic                r_avail, r_crc_ok, r_pid_err, r_len_err, r_dropped;
    logic [3:0]          r_pid, r_endp;
    logic [6:0]          r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [LEN_W-1:0]    r_len;

    always_ff @(posedge clk) begin
        if (!rst_b || (w_clear && !w_load)) begin
            r_avail   <= 1'b0;
            r_pid     <= '0;
            r_addr    <= '0;
            r_endp    <= '0;
            r_data    <= '0;
            r_len     <= '0;
            r_crc_ok  <= 1'b0;
            r_pid_err <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_load) begin
            r_avail   <= 1'b1;
            r_pid     <= w_pid_nx[3:0];
            r_addr    <= w_e_addr;
            r_endp    <= w_e_endp;
            r_data    <= w_e_data;
            r_len     <= w_e_len;
            r_crc_ok  <= w_e_crc_ok;
            r_pid_err <= w_e_pid_err;
            r_len_err <= w_e_len_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
        end
    end

    assign bus.pktOutAvail = r_avail;
    assign bus.pid         = r_pid;
    assign bus.addr        = r_addr;
    assign bus.endp        = r_endp;
    assign bus.data        = r_data;
    assign bus.dataLen     = r_len;
    assign bus.crcOk       = r_crc_ok;
    assign bus.pidErr      = r_pid_err;
    assign bus.lenErr      = r_len_err;
    assign bus.dropped     = r_dropped;
endmodule
`default_nettype wire

// File: doc/crc_decoding.md
Name: crc_decoding

Overview:
Receive-side counterpart of the token CRC5 encoder. Consumes a de-stuffed, NRZI-decoded serial bit stream one bit per strobe and assembles the PID and token or data fields. Checks PID integrity, field length and CRC (CRC5 for tokens, CRC16 for data) on the fly, then presents the decoded packet to the protocol layer under a valid/ack handshake. Sits between the bit-unstuffer and the protocol FSM.

Parameters:
MAX_BYTES, 8, maximum data payload bytes stored (buffer = MAX_BYTES*8+16 bits)

Ports:
clk  input  1  system clock
rst_b  input  1  synchronous active-low reset
bIn  input  1  received bit, wire order (LSB of each field first)
bInAvail  input  1  bIn valid this cycle
pktEnd  input  1  end-of-packet strobe (EOP seen)
pktOutAvail  output  1  decoded packet valid; held until acked
pktAck  input  1  consumer accepts packet
pid  output  4  PID[3:0]
addr  output  7  token address
endp  output  4  token endpoint
data  output  MAX_BYTES*8  payload, byte 0 in [7:0]; bits >= 8*dataLen forced 0
dataLen  output  $clog2(MAX_BYTES+1)  payload byte count
crcOk  output  1  CRC residual correct and no pidErr/lenErr
pidErr  output  1  PID check nibble mismatch or unknown PID
lenErr  output  1  body bit count illegal for PID type
dropped  output  1  1-cycle pulse: bInAvail or pktEnd arrived while holding

Behaviour:
- Reset (rst_b=0 at posedge): state IDLE, all outputs 0, bit counter 0, CRC5 reg 5'h1F, CRC16 reg 16'hFFFF, buffer cleared.
- States: IDLE, PID, BODY, HOLD.
- IDLE: bInAvail -> store bit at pidRaw[0], counter=1, go PID. pktEnd alone is ignored.
- PID: each bInAvail stores pidRaw[counter]; 8th bit -> go BODY, counter=0, CRC5 reg=5'h1F, CRC16 reg=16'hFFFF. pktEnd before 8 bits -> pidErr=1, lenErr=1, go HOLD.
- BODY: each bInAvail writes buf[counter] if counter < MAX_BYTES*8+16 and increments counter (saturates, no wrap). Both CRC regs shift every body bit: CRC5 taps x^5+x^2+1, feedback = reg[4]^bIn; CRC16 taps x^16+x^15+x^2+1, feedback = reg[15]^bIn.
- bInAvail and pktEnd in the same cycle: the bit is consumed first, then end evaluation includes it.
- On pktEnd in BODY: register results, go HOLD; pktOutAvail rises the next cycle.
- PID classes: token (OUT 0001, IN 1001, SOF 0101, SETUP 1101) needs exactly 16 body bits; data (DATA0 0011, DATA1 1011) needs 16 + 8n bits, n <= MAX_BYTES; handshake (ACK 0010, NAK 1010, STALL 1110) needs 0 body bits. Any other value, or pidRaw[7:4] != ~pidRaw[3:0], sets pidErr.
- lenErr is set on any count violation, including a saturated counter.
- Token: addr = buf[6:0], endp = buf[10:7]; good when CRC5 reg == 5'h0C.
- Data: dataLen = (count-16)/8; good when CRC16 reg == 16'h800D.
- Handshake: crcOk = ~lenErr.
- Non-token packets drive addr/endp 0. crcOk = 0 whenever pidErr or lenErr.
- HOLD: outputs stable; incoming bits/pktEnd ignored with a dropped pulse. pktAck=1 sampled in HOLD -> outputs cleared and IDLE next cycle. pktAck outside HOLD is ignored.
- Reset mid-packet or mid-HOLD: immediate return to reset values; no partial result is emitted.

Optional Feature:
CRC16_CHECK_EN
- Defined: CRC16 register and data residual check as above.
- Undefined: no CRC16 logic; data packets still captured and length-checked, with crcOk = ~lenErr.

Test Plan:
- SETUP token bytes 2D 00 10 sent LSB first, then pktEnd -> pktOutAvail=1, pid=1101, addr=0, endp=0, crcOk=1, pidErr=0, lenErr=0; held until pktAck, then IDLE.
- Same token with body bit 3 flipped -> crcOk=0, addr=0x08, pidErr=0, lenErr=0.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94 -> pid=0011, dataLen=8, data=64'h0040_0000_0100_0680, crcOk=1; empty DATA0 C3 00 00 -> dataLen=0, crcOk=1.
- ACK byte D2 then pktEnd -> pid=0010, crcOk=1. PID byte 2E (check nibble wrong) -> pidErr=1, crcOk=0. Token with 15 body bits -> lenErr=1.
- While in HOLD, drive 3 bInAvail strobes -> 3 dropped pulses, outputs unchanged. pktAck -> next packet decodes correctly.
- rst_b=0 after 5 body bits of a token -> no pktOutAvail; the following clean IN token 69 00 10 -> pid=1001, crcOk=1.
